// File: rtl/fc_classifier.sv
// Fully connected output layer: N_OUT parallel MAC lanes over an N_IN-feature frame, then serial scores, argmax and done.
// Scores start 3 cycles after the last accepted feature; no backpressure, beats outside ACCUM or beyond N_IN are dropped.
module fc_classifier #(
  parameter int N_IN   = 169,
  parameter int N_OUT  = 4,
  parameter int FEAT_W = 22,
  parameter int WGT_W  = 8,
  parameter int ACC_W  = 40
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_signal,
  input  logic                          feature_valid,
  input  logic signed [FEAT_W-1:0]      feature_in,
  input  logic                          wgt_we,
  input  logic [$clog2(N_OUT*N_IN)-1:0] wgt_addr,
  input  logic signed [WGT_W-1:0]       wgt_data,
  output logic signed [ACC_W-1:0]       score_out,
  output logic [$clog2(N_OUT)-1:0]      score_idx,
  output logic                          score_valid,
  output logic [$clog2(N_OUT)-1:0]      class_out,
  output logic                          class_valid,
  output logic                          done_signal,
  output logic                          busy
);

  localparam int NW = N_OUT * N_IN;
  localparam int AW = $clog2(NW);
  localparam int IW = $clog2(N_OUT);
  localparam int CW = $clog2(N_IN + 1);
  localparam int PW = FEAT_W + WGT_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_OUTPUT,
    S_DONE
  } state_t;

  logic signed [WGT_W-1:0] wmem [NW];
  logic signed [WGT_W-1:0] wrow [N_OUT];
  logic [CW-1:0]           rd_idx;
  logic                    wr_ok;
  logic                    accept;
  logic                    new_max;
  logic [IW-1:0]           nxt_idx;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    s1_vld_q, s1_vld_d;
  logic signed [PW-1:0]    prod_q [N_OUT];
  logic signed [PW-1:0]    prod_d [N_OUT];
  logic signed [ACC_W-1:0] acc_q [N_OUT];
  logic signed [ACC_W-1:0] acc_d [N_OUT];
  logic                    drain_q, drain_d;
  logic signed [ACC_W-1:0] score_out_q, score_out_d;
  logic [IW-1:0]           score_idx_q, score_idx_d;
  logic                    score_valid_q, score_valid_d;
  logic signed [ACC_W-1:0] max_q, max_d;
  logic [IW-1:0]           max_idx_q, max_idx_d;
  logic [IW-1:0]           class_out_q, class_out_d;
  logic                    class_valid_q, class_valid_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;

  // Weight RAM is deliberately outside the reset domain so weights survive rst.
  assign wr_ok = wgt_we && ((state_q == S_IDLE) || (state_q == S_DONE)) && (wgt_addr < AW'(NW));

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      wmem[wgt_addr] <= wgt_data;
    end
  end

  always_comb begin
    rd_idx = (cnt_q < CW'(N_IN)) ? cnt_q : '0;
    for (int j = 0; j < N_OUT; j++) begin
      wrow[j] = wmem[AW'(j * N_IN) + AW'(rd_idx)];
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    s1_vld_d      = 1'b0;
    prod_d        = prod_q;
    acc_d         = acc_q;
    drain_d       = drain_q;
    score_out_d   = score_out_q;
    score_idx_d   = score_idx_q;
    score_valid_d = 1'b0;
    max_d         = max_q;
    max_idx_d     = max_idx_q;
    class_out_d   = class_out_q;
    class_valid_d = 1'b0;
    done_d        = 1'b0;
    nxt_idx       = score_idx_q + 1'b1;
    new_max       = (score_idx_q == '0) || (score_out_q > max_q);
    accept        = (state_q == S_ACCUM) && feature_valid && !start_signal &&
                    (cnt_q < CW'(N_IN));

    // Stage 2 keeps running through DRAIN so the last product lands.
    if (s1_vld_q) begin
      for (int j = 0; j < N_OUT; j++) begin
        acc_d[j] = acc_q[j] + ACC_W'(prod_q[j]);
      end
    end

    if (accept) begin
      for (int j = 0; j < N_OUT; j++) begin
        prod_d[j] = PW'(feature_in) * PW'(wrow[j]);
      end
      s1_vld_d = 1'b1;
      cnt_d    = cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: ;
      S_ACCUM: begin
        if (accept && (cnt_q == CW'(N_IN - 1))) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end
      end
      S_DRAIN: begin
        if (drain_q) begin
          state_d       = S_OUTPUT;
          score_valid_d = 1'b1;
          score_idx_d   = '0;
          score_out_d   = acc_q[0];
        end else begin
          drain_d = 1'b1;
        end
      end
      S_OUTPUT: begin
        if (new_max) begin
          max_d     = score_out_q;
          max_idx_d = score_idx_q;
        end
        if (score_idx_q == IW'(N_OUT - 1)) begin
          state_d       = S_DONE;
          class_out_d   = new_max ? score_idx_q : max_idx_q;
          class_valid_d = 1'b1;
          done_d        = 1'b1;
        end else begin
          score_valid_d = 1'b1;
          score_idx_d   = nxt_idx;
          score_out_d   = acc_q[nxt_idx];
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A new frame start overrides everything, including an in-flight score burst.
    if (start_signal) begin
      state_d       = S_ACCUM;
      cnt_d         = '0;
      s1_vld_d      = 1'b0;
      score_valid_d = 1'b0;
      class_valid_d = 1'b0;
      done_d        = 1'b0;
      for (int j = 0; j < N_OUT; j++) begin
        acc_d[j] = '0;
      end
    end

    busy_d = (state_d == S_ACCUM) || (state_d == S_DRAIN) || (state_d == S_OUTPUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      s1_vld_q      <= 1'b0;
      drain_q       <= 1'b0;
      score_out_q   <= '0;
      score_idx_q   <= '0;
      score_valid_q <= 1'b0;
      max_q         <= '0;
      max_idx_q     <= '0;
      class_out_q   <= '0;
      class_valid_q <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      for (int j = 0; j < N_OUT; j++) begin
        prod_q[j] <= '0;
        acc_q[j]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      s1_vld_q      <= s1_vld_d;
      drain_q       <= drain_d;
      score_out_q   <= score_out_d;
      score_idx_q   <= score_idx_d;
      score_valid_q <= score_valid_d;
      max_q         <= max_d;
      max_idx_q     <= max_idx_d;
      class_out_q   <= class_out_d;
      class_valid_q <= class_valid_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      for (int j = 0; j < N_OUT; j++) begin
        prod_q[j] <= prod_d[j];
        acc_q[j]  <= acc_d[j];
      end
    end
  end

  assign score_out   = score_out_q;
  assign score_idx   = score_idx_q;
  assign score_valid = score_valid_q;
  assign class_out   = class_out_q;
  assign class_valid = class_valid_q;
  assign done_signal = done_q;
  assign busy        = busy_q;

endmodule

// File: doc/fc_classifier.md
Name: fc_classifier

Overview:
- Fully connected output layer directly downstream of the feature extraction stage (conv -> activation -> max-pool).
- Consumes the pooled 22-bit signed feature stream one value per valid beat and multiply-accumulates each feature against N_OUT weight rows held in an internal weight RAM.
- After N_IN features, emits the N_OUT class scores serially, then the argmax class index, then a done pulse.

Parameters:
- N_IN, 169, features per frame (13x13 pooled map)
- N_OUT, 4, output classes; number of parallel MAC lanes
- FEAT_W, 22, signed feature width
- WGT_W, 8, signed weight width
- ACC_W, 40, signed accumulator and score width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- start_signal  in  1  frame start pulse; clears accumulators and feature counter
- feature_valid  in  1  feature_in valid this cycle
- feature_in  in  FEAT_W  signed pooled feature
- wgt_we  in  1  weight write enable
- wgt_addr  in  clog2(N_OUT*N_IN)  weight address = class*N_IN + feature index
- wgt_data  in  WGT_W  signed weight
- score_out  out  ACC_W  signed class score
- score_idx  out  clog2(N_OUT)  class index of score_out
- score_valid  out  1  score_out/score_idx valid
- class_out  out  clog2(N_OUT)  argmax class
- class_valid  out  1  one-cycle pulse, class_out valid
- done_signal  out  1  one-cycle pulse, frame complete
- busy  out  1  high in ACCUM, DRAIN and OUTPUT

Behaviour:
- Reset: the FSM goes to IDLE and every output is 0. Accumulators and the feature counter clear; the weight RAM is not cleared.
- FSM states: IDLE, ACCUM, DRAIN, OUTPUT, DONE.
- IDLE -> ACCUM on start_signal. In any state, start_signal clears the accumulators, the counter and the pipeline valid bits, aborts any score output, and enters ACCUM the next cycle.
- ACCUM:
  - Each feature_valid beat with count < N_IN is accepted.
  - Stage 1 registers N_OUT products feature_in * W[j][count], each FEAT_W+WGT_W = 30 bits signed.
  - Stage 2 sign-extends each product to ACC_W and adds it to acc[j].
  - count increments per accepted beat; on the beat with count = N_IN-1 the FSM goes to DRAIN.
- DRAIN: 2 cycles to flush the MAC pipeline; no features are accepted. Then the FSM goes to OUTPUT.
- Features arriving outside ACCUM are ignored.
- Gaps in feature_valid are allowed and stall nothing. Only the beat count matters.
- Latency: if the last feature is accepted at cycle t, score_valid rises at t+3.
- OUTPUT:
  - score_valid is high for N_OUT consecutive cycles, with score_idx = 0..N_OUT-1 and score_out = acc[score_idx].
  - The running max updates with strict greater-than, so the lowest index wins ties.
- DONE: a single cycle, entered the cycle after the last score. class_out and class_valid are registered here, together with done_signal; class_valid and done_signal pulse in this same cycle.
- Then the FSM returns to IDLE. class_out holds its value until the next DONE; score_out holds its last value.
- Arithmetic is two's complement with wrap-around at ACC_W and no saturation. With the default widths an overflow cannot occur for N_IN <= 1024.
- Weight writes:
  - Accepted only in IDLE or DONE; ignored while busy.
  - Addresses >= N_OUT*N_IN are ignored.
  - A write completes in 1 cycle, and a read issued the cycle after sees the new value.
- Weight RAM read: combinational on index count for all N_OUT rows. One read port per lane is allowed, or a single N_OUT*WGT_W-wide word per feature index.
- start_signal and feature_valid in the same cycle: the clear wins and that feature is dropped.

Test Plan:
- Reset mid-ACCUM (rst at feature 50) -> all outputs 0, busy 0, and the following start plus a full frame give correct scores. Weights loaded before the reset are retained.
- Load all weights = 1 and stream features 0..168 -> scores all 14196 (sum 0..168). class_out = 0 (tie rule), with class_valid and done_signal pulsing 1 cycle after score_idx 3.
- Weights: row 2 = +2, row 0 = -1, rows 1,3 = 0; all features = 1000 -> scores -169000, 0, 338000, 0, and class_out = 2.
- Feature = -(2^21) (min) with weight -128 on every beat -> each product = 268435456, the score is 169*268435456 = 45365592064, and no wrap occurs. The score_valid rise is checked at exactly t+3 after the last accepted beat.
- Random valid gaps (30% idle) plus extra features after the 169th, plus a wgt_we during ACCUM -> scores identical to the gap-free run, the extra features ignored, the weight unchanged.
- start_signal asserted during OUTPUT after score_idx 1 -> score_valid drops the next cycle, no class_valid or done_signal, accumulators cleared, and the new frame completes correctly.
